// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg
// Shared definitions for the SPI client scheduler: requester count, the
// scheduler state encoding and the slave-select codes that the top-level
// decoder turns into the five active-low selects.
package spi_sched_pkg;

    // Requester index equals its slave-select code.
    localparam int NREQ = 5;
    localparam int PW   = $clog2(NREQ);

    localparam logic [2:0] SS_TRIG = 3'd0;
    localparam logic [2:0] SS_CH1  = 3'd1;
    localparam logic [2:0] SS_CH2  = 3'd2;
    localparam logic [2:0] SS_CH3  = 3'd3;
    localparam logic [2:0] SS_EEP  = 3'd4;
    localparam logic [2:0] SS_NONE = 3'd7;   // decodes to no select

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // One-hot vector with bit idx set.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/spi_sched_rr_pick.sv
// rr_pick
// Combinational round-robin winner search: starting at ptr and wrapping
// past NREQ-1, returns the first requester whose req bit is set.
//   req  in   NREQ  pending requests
//   ptr  in   PW    index searched first
//   any  out  1     at least one request pending
//   w    out  PW    winning requester index (0 when any is low)
module rr_pick
    import spi_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   w
);

    logic [PW:0] w_sum;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a combinational signal unassigned and no latch is inferred.
        any   = 1'b0;
        w     = '0;
        w_sum = '0;
        // Walk from the farthest offset down to ptr itself; the last hit
        // written is the nearest one, which is the round-robin winner.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (req[w_sum[PW-1:0]]) begin
                any = 1'b1;
                w   = w_sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_sched.sv
// spi_sched
// Round-robin scheduler sharing one SPI master between the trigger pot, the
// three channel-gain pots and the calibration EEPROM. Grants one requester,
// starts the master with its command, waits for completion or timeout and
// reports done/err back to that requester.
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   req           in   level request per requester, held until done/err
//   req_cmd       in   16-bit command per requester, sampled at grant
//   gnt           out  one-hot grant, ISSUE through end of WAIT
//   done / err    out  one-hot single-cycle completion / timeout pulse
//   rdata         out  master read-back captured at SPI_done
//   busy          out  high whenever not IDLE
//   wrt_SPI       out  single-cycle start pulse to the master
//   SPI_cmd, ss   out  command and slave-select code, held until next grant
//   SPI_done      in   master completion pulse
//   SPI_data_out  in   master shift-in data, valid with SPI_done
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_cmd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [15:0]          rdata,
    output logic                 busy,
    output logic                 wrt_SPI,
    output logic [15:0]          SPI_cmd,
    output logic [2:0]           ss,
    input  logic                 SPI_done,
    input  logic [15:0]          SPI_data_out
);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_w;
    logic [TW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic [15:0]     r_rdata;
    logic            r_busy;
    logic            r_wrt;
    logic [15:0]     r_cmd;
    logic [2:0]      r_ss;

    logic            w_any;
    logic [PW-1:0]   w_win;
    logic [15:0]     w_cmd [NREQ];

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .w   (w_win)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_cmd[i] = req_cmd[16*i +: 16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_w     <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_wrt   <= 1'b0;
            r_cmd   <= '0;
            r_ss    <= SS_NONE;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge register values regardless of statement order.
            // Pulse outputs fall back to zero unless a transition raises them.
            r_wrt  <= 1'b0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ISSUE;
                        r_w     <= w_win;
                        r_cmd   <= w_cmd[w_win];
                        r_ss    <= w_win;
                        r_gnt   <= onehot(w_win);
                        r_wrt   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                end
                WAIT: begin
                    // SPI_done is checked first so it wins over a coinciding timeout.
                    if (SPI_done) begin
                        r_rdata <= SPI_data_out;
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= DONE;
                    end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                        r_err   <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                DONE: begin
                    // Rotate past the requester just served for fairness.
                    r_ptr   <= (r_w == PW'(NREQ - 1)) ? '0 : r_w + PW'(1);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign wrt_SPI = r_wrt;
    assign SPI_cmd = r_cmd;
    assign ss      = r_ss;

endmodule

// File: tb/tb_spi_sched.sv
// tb_spi_sched
// Self-checking bench for spi_sched. Clients are modelled as a pending-request
// vector; the expected winner, outputs and completion cycle of every
// transaction come from a transaction-level round-robin model.
module tb_spi_sched;
    import spi_sched_pkg::*;

    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_cmd;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic [15:0]          rdata;
    logic                 busy;
    logic                 wrt_SPI;
    logic [15:0]          SPI_cmd;
    logic [2:0]           ss;
    logic                 SPI_done;
    logic [15:0]          SPI_data_out;

    always #5 clk = ~clk;

    spi_sched #(.TIMEOUT(TO), .TW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_cmd      (req_cmd),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .wrt_SPI      (wrt_SPI),
        .SPI_cmd      (SPI_cmd),
        .ss           (ss),
        .SPI_done     (SPI_done),
        .SPI_data_out (SPI_data_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NREQ-1:0] pend;
    logic [15:0]     cmd_m [NREQ];
    int              mptr;
    logic [15:0]     last_rdata;
    int              grant_log [$];
    int              done_cnt [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First pending requester at or after p, wrapping modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] rr;
        for (int k = 0; k < NREQ; k++) begin
            rr = r >> ((p + k) % NREQ);
            if (rr[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        req = pend;
        for (int i = 0; i < NREQ; i++) req_cmd[16*i +: 16] = cmd_m[i];
    endtask

    // Entered in an IDLE cycle with pend non-zero and driven; returns in the
    // following IDLE cycle. lat = WAIT cycle in which SPI_done is returned,
    // lat >= TO means the master never answers.
    task automatic serve(input int lat, input logic [15:0] data, input bit keep, input bit stray);
        int              w;
        logic [NREQ-1:0] oh;
        bit              ok;
        w = pick(pend, mptr);
        if (w < 0) return;
        oh = onehot(PW'(w));
        ok = (lat < TO);

        step();  // ISSUE
        check("issue_wrt",  32'(wrt_SPI), 32'd1);
        check("issue_gnt",  32'(gnt), 32'(oh));
        check("issue_ss",   32'(ss), 32'(w));
        check("issue_cmd",  32'(SPI_cmd), 32'(cmd_m[w]));
        check("issue_busy", 32'(busy), 32'd1);
        grant_log.push_back(w);
        if (stray) begin
            SPI_done     = 1'b1;
            SPI_data_out = 16'hDEAD;
        end

        step();  // WAIT cycle 0
        SPI_done = 1'b0;
        check("wait_wrt", 32'(wrt_SPI), 32'd0);
        for (int j = 0; j < TO; j++) begin
            if (j == lat) begin
                SPI_done     = 1'b1;
                SPI_data_out = data;
            end
            step();
            SPI_done     = 1'b0;
            SPI_data_out = 16'($urandom);
            if (j == lat) break;
            if (j < TO - 1) begin
                check("wait_gnt",   32'(gnt), 32'(oh));
                check("wait_flags", 32'({done, err}), 32'd0);
            end
        end

        // DONE cycle
        check("done_pulse", 32'(done), ok ? 32'(oh) : 32'd0);
        check("err_pulse",  32'(err),  ok ? 32'd0 : 32'(oh));
        check("done_gnt",   32'(gnt), 32'd0);
        check("done_busy",  32'(busy), 32'd1);
        if (ok) begin
            last_rdata = data;
            done_cnt[w]++;
        end
        check("done_rdata", 32'(rdata), 32'(last_rdata));
        mptr = (w + 1) % NREQ;
        if (!keep) pend &= ~oh;
        drive_req();

        step();  // IDLE
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_flags", 32'({done, err, gnt}), 32'd0);
        check("idle_wrt",   32'(wrt_SPI), 32'd0);
        check("hold_ss",    32'(ss), 32'(w));
        check("hold_cmd",   32'(SPI_cmd), 32'(cmd_m[w]));
        check("hold_rdata", 32'(rdata), 32'(last_rdata));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
        check({tag, "_wrt"},   32'(wrt_SPI), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_cmd"},   32'(SPI_cmd), 32'd0);
        check({tag, "_ss"},    32'(ss), 32'(SS_NONE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        rst          = 1'b1;
        SPI_done     = 1'b0;
        SPI_data_out = '0;
        pend         = '0;
        mptr         = 0;
        last_rdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cmd_m[i]    = '0;
            done_cnt[i] = 0;
        end
        drive_req();
        repeat (3) step();
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (3) begin
            step();
            check("release_wrt",  32'(wrt_SPI), 32'd0);
            check("release_busy", 32'(busy), 32'd0);
        end

        // All five request together: served 0..4, one done each.
        s    = grant_log.size();
        pend = 5'b11111;
        for (int i = 0; i < NREQ; i++) cmd_m[i] = 16'($urandom);
        drive_req();
        for (int k = 0; k < NREQ; k++) serve($urandom_range(0, TO - 2), 16'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < NREQ; k++) begin
            check("simul_order", 32'(grant_log[s + k]), 32'(k));
            check("simul_done_once", 32'(done_cnt[k]), 32'd1);
        end

        // Single request from ch1.
        pend     = 5'b00010;
        cmd_m[1] = 16'hA5C3;
        drive_req();
        serve(2, 16'h0042, 1'b0, 1'b0);
        check("single_rdata", 32'(rdata), 32'h0042);

        // Fairness: req0 held, req3 raised after req0's first grant.
        s    = grant_log.size();
        pend = 5'b00001;
        drive_req();
        serve(1, 16'($urandom), 1'b1, 1'b0);
        pend |= 5'b01000;
        drive_req();
        serve(3, 16'($urandom), 1'b0, 1'b0);
        serve(0, 16'($urandom), 1'b0, 1'b0);
        check("fair_g0", 32'(grant_log[s]),     32'd0);
        check("fair_g1", 32'(grant_log[s + 1]), 32'd3);
        check("fair_g2", 32'(grant_log[s + 2]), 32'd0);

        // Timeout, then a normal transaction on the same requester.
        pend = 5'b00100;
        drive_req();
        serve(TO, 16'hBEEF, 1'b0, 1'b0);
        pend = 5'b00100;
        drive_req();
        serve(4, 16'h1234, 1'b0, 1'b0);

        // SPI_done coinciding with the last counted WAIT cycle.
        pend = 5'b01000;
        drive_req();
        serve(TO - 1, 16'h5A5A, 1'b0, 1'b0);

        // Stray SPI_done in IDLE and in ISSUE.
        pend = '0;
        drive_req();
        SPI_done = 1'b1;
        step();
        SPI_done = 1'b0;
        check("stray_idle_done", 32'(done), 32'd0);
        check("stray_idle_busy", 32'(busy), 32'd0);
        pend = 5'b10000;
        drive_req();
        serve(5, 16'h0F0F, 1'b0, 1'b1);

        // Randomized client traffic.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((pend & onehot(PW'(i))) == '0 && $urandom_range(0, 2) == 0) begin
                    pend     |= onehot(PW'(i));
                    cmd_m[i]  = 16'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) pend &= ~onehot(PW'($urandom_range(0, NREQ - 1)));
            drive_req();
            if (pend == '0) begin
                step();
                check("rand_idle_wrt",  32'(wrt_SPI), 32'd0);
                check("rand_idle_busy", 32'(busy), 32'd0);
            end else begin
                serve(($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                      16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            end
        end

        // Reset in the middle of WAIT, with the arbitration pointer away from 0.
        pend = 5'b00100;
        drive_req();
        serve(1, 16'h7777, 1'b0, 1'b0);
        pend = 5'b10000;
        drive_req();
        step();  // ISSUE
        check("abort_gnt", 32'(gnt), 32'(onehot(PW'(4))));
        pend = '0;
        step();  // WAIT
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        drive_req();
        step();
        rst = 1'b0;
        mptr       = 0;
        last_rdata = '0;
        SPI_done     = 1'b1;
        SPI_data_out = 16'hCAFE;
        step();
        SPI_done = 1'b0;
        check("post_rst_stray_done",  32'(done), 32'd0);
        check("post_rst_stray_busy",  32'(busy), 32'd0);
        check("post_rst_stray_rdata", 32'(rdata), 32'd0);
        step();
        check("post_rst_no_wrt", 32'(wrt_SPI), 32'd0);
        pend = 5'b11111;
        for (int i = 0; i < NREQ; i++) cmd_m[i] = 16'($urandom);
        drive_req();
        serve(2, 16'($urandom), 1'b0, 1'b0);
        check("post_rst_first", 32'(grant_log[$]), 32'd0);
        for (int k = 1; k < NREQ; k++) serve($urandom_range(0, TO - 2), 16'($urandom), 1'b0, 1'b0);
        check("post_rst_drained", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
